uart_tx_arbiter: RTL

Round-robin arbiter that shares one `uart_data_tx` word transmitter among `NUM_REQ` requesters. It sits between requesting logic (PLC status, loopback echo, debug) and the transmitter's `data`/`send_en`/`Tx_Done` ports. It grants one word at a time, launches it, and holds ownership until `Tx_Done` or a watchdog timeout. After each transfer, priority rotates so that no requester starves.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signals of the UART word-transmit arbiter.
// master = requesters plus transmitter done feedback, slave = arbiter.
// Pure wiring; no storage, so it adds no latency and no backpressure.
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_send_en;
    logic                          tx_done;
    logic                          busy;
    logic [IDX_W-1:0]              owner;
    logic                          timeout_err;

    modport master (
        output req, req_data, tx_done,
        input  grant, tx_data, tx_send_en, busy, owner, timeout_err
    );

    modport slave (
        input  req, req_data, tx_done,
        output grant, tx_data, tx_send_en, busy, owner, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one word transmitter among NUM_REQ requesters.
// Latency: grant/tx_send_en/tx_data registered one edge after req is sampled in IDLE.
// Backpressure: owns the transmitter until tx_done or watchdog expiry; req ignored meanwhile.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               Clk,
    input  logic               Rst_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  send_q, send_d;
    logic                  busy_q, busy_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  terr_q, terr_d;

    logic                  win_vld;
    logic [IDX_W-1:0]      win_idx;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        grant_d   = '0;
        tx_data_d = tx_data_q;
        send_d    = 1'b0;
        owner_d   = owner_q;
        terr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d   = NUM_REQ'(1) << win_idx;
                    tx_data_d = bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    send_d    = 1'b1;
                    owner_d   = win_idx;
                    ptr_d     = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
                    wd_d      = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done pulse coincident with our own send strobe belongs to an older frame.
                if (bus.tx_done && !send_q) begin
                    state_d = S_IDLE;
                    wd_d    = '0;
                end else if (wd_q == WD_LAST) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            wd_q      <= '0;
            grant_q   <= '0;
            tx_data_q <= '0;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            send_q    <= send_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_send_en  = send_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = terr_q;
endmodule
